// File: rtl/pong_pkg.sv
// Shared Pong definitions: FSM state, motion direction encodings and the
// default screen/paddle geometry used by the ball, paddle and render blocks.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SERVE_WAIT = 2'd1,
    PLAY       = 2'd2,
    SCORED     = 2'd3
  } state_t;

  typedef enum logic {
    DX_RIGHT = 1'b0,
    DX_LEFT  = 1'b1
  } dx_t;

  typedef enum logic {
    DY_DOWN = 1'b0,
    DY_UP   = 1'b1
  } dy_t;

  localparam int POS_W = 10;
  // One extra bit so sums like x + size + step never wrap.
  localparam int ARITH_W = POS_W + 1;

  localparam int DEF_SCREEN_W      = 640;
  localparam int DEF_SCREEN_H      = 480;
  localparam int DEF_BALL_SIZE     = 8;
  localparam int DEF_PADDLE_W      = 8;
  localparam int DEF_PADDLE_H      = 64;
  localparam int DEF_LEFT_PADDLE_X = 16;
  localparam int DEF_RIGHT_PADDLE_X = 616;
  localparam int DEF_STEP          = 4;
  localparam int DEF_SERVE_TICKS   = 50;

endpackage

// File: rtl/pong_ball_if.sv
// Ball engine signal bundle: game-side controls in, ball position and events out.
interface pong_ball_if;
  import pong_pkg::*;

  logic             gClk;
  logic             serve;
  logic [POS_W-1:0] left_paddle_y;
  logic [POS_W-1:0] right_paddle_y;
  logic [POS_W-1:0] ball_x;
  logic [POS_W-1:0] ball_y;
  logic             ball_active;
  logic             hit_pulse;
  logic             score_left_pulse;
  logic             score_right_pulse;

  modport master (
    output gClk, serve, left_paddle_y, right_paddle_y,
    input  ball_x, ball_y, ball_active, hit_pulse,
           score_left_pulse, score_right_pulse
  );

  modport slave (
    input  gClk, serve, left_paddle_y, right_paddle_y,
    output ball_x, ball_y, ball_active, hit_pulse,
           score_left_pulse, score_right_pulse
  );

endinterface

// File: rtl/game_tick_edge.sv
// Rising-edge detector for the slow game clock level, one clk-wide tick out.
module game_tick_edge (
  input  logic clk,
  input  logic rst,
  input  logic lvl,
  output logic tick
);

  logic lvl_d;

  always_ff @(posedge clk) begin
    if (rst) lvl_d <= 1'b0;
    else     lvl_d <= lvl;
  end

  assign tick = lvl & ~lvl_d;

endmodule

// File: rtl/pong_ball.sv
// Pong ball-motion engine: serve delay, per-tick motion with wall and paddle
// bounces, and one-cycle hit/score event pulses.
module pong_ball
  import pong_pkg::*;
#(
  parameter int SCREEN_W       = DEF_SCREEN_W,
  parameter int SCREEN_H       = DEF_SCREEN_H,
  parameter int BALL_SIZE      = DEF_BALL_SIZE,
  parameter int PADDLE_W       = DEF_PADDLE_W,
  parameter int PADDLE_H       = DEF_PADDLE_H,
  parameter int LEFT_PADDLE_X  = DEF_LEFT_PADDLE_X,
  parameter int RIGHT_PADDLE_X = DEF_RIGHT_PADDLE_X,
  parameter int STEP           = DEF_STEP,
  parameter int SERVE_TICKS    = DEF_SERVE_TICKS
) (
  input  logic        clk,
  input  logic        rst,
  pong_ball_if.slave  bus
);

  localparam int CNT_W = $clog2(SERVE_TICKS + 1);
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_TICKS);

  localparam logic [ARITH_W-1:0] C_W    = ARITH_W'(SCREEN_W);
  localparam logic [ARITH_W-1:0] C_BS   = ARITH_W'(BALL_SIZE);
  localparam logic [ARITH_W-1:0] C_PH   = ARITH_W'(PADDLE_H);
  localparam logic [ARITH_W-1:0] C_STEP = ARITH_W'(STEP);
  localparam logic [ARITH_W-1:0] C_YMAX = ARITH_W'(SCREEN_H - BALL_SIZE);
  localparam logic [ARITH_W-1:0] C_RFACE = ARITH_W'(RIGHT_PADDLE_X);
  localparam logic [ARITH_W-1:0] C_LFACE = ARITH_W'(LEFT_PADDLE_X + PADDLE_W);
  localparam logic [ARITH_W-1:0] C_RSTOP = ARITH_W'(RIGHT_PADDLE_X - BALL_SIZE);
  localparam logic [POS_W-1:0]   CX = POS_W'(SCREEN_W / 2 - BALL_SIZE / 2);
  localparam logic [POS_W-1:0]   CY = POS_W'(SCREEN_H / 2 - BALL_SIZE / 2);

  logic tick;

  game_tick_edge u_tick (
    .clk  (clk),
    .rst  (rst),
    .lvl  (bus.gClk),
    .tick (tick)
  );

  state_t           state, state_n;
  dx_t              dx, dx_n;
  dy_t              dy, dy_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [POS_W-1:0] ball_x, ball_y, x_n, y_n;
  logic             hit_q, sl_q, sr_q, hit_n, sl_n, sr_n;

  logic [ARITH_W-1:0] xw, yw, lyw, ryw, xs, ys;
  logic               ovl_l, ovl_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      dx     <= DX_RIGHT;
      dy     <= DY_DOWN;
      cnt    <= '0;
      ball_x <= CX;
      ball_y <= CY;
      hit_q  <= 1'b0;
      sl_q   <= 1'b0;
      sr_q   <= 1'b0;
    end else begin
      state  <= state_n;
      dx     <= dx_n;
      dy     <= dy_n;
      cnt    <= cnt_n;
      ball_x <= x_n;
      ball_y <= y_n;
      hit_q  <= hit_n;
      sl_q   <= sl_n;
      sr_q   <= sr_n;
    end
  end

  assign xw      = {1'b0, ball_x};
  assign yw      = {1'b0, ball_y};
  assign lyw     = {1'b0, bus.left_paddle_y};
  assign ryw     = {1'b0, bus.right_paddle_y};
  assign cnt_inc = cnt + CNT_W'(1);

  // Overlap is judged on the pre-update y so both axes see the same snapshot.
  assign ovl_l = (yw + C_BS > lyw) && (yw < lyw + C_PH);
  assign ovl_r = (yw + C_BS > ryw) && (yw < ryw + C_PH);

  always_comb begin
    state_n = state;
    dx_n    = dx;
    dy_n    = dy;
    cnt_n   = cnt;
    x_n     = ball_x;
    y_n     = ball_y;
    hit_n   = 1'b0;
    sl_n    = 1'b0;
    sr_n    = 1'b0;
    xs      = xw;
    ys      = yw;

    unique case (state)
      IDLE: begin
        x_n = CX;
        y_n = CY;
        if (bus.serve) begin
          cnt_n   = '0;
          state_n = SERVE_WAIT;
        end
      end

      SERVE_WAIT: begin
        if (tick) begin
          cnt_n = cnt_inc;
          if (cnt_inc == SERVE_LAST) state_n = PLAY;
        end
      end

      PLAY: begin
        if (tick) begin
          if (dy == DY_DOWN) begin
            if (yw + C_STEP >= C_YMAX) begin
              ys   = C_YMAX;
              dy_n = DY_UP;
            end else begin
              ys = yw + C_STEP;
            end
          end else begin
            if (yw <= C_STEP) begin
              ys   = '0;
              dy_n = DY_DOWN;
            end else begin
              ys = yw - C_STEP;
            end
          end

          if (dx == DX_RIGHT) begin
            if ((xw + C_BS <= C_RFACE) && (xw + C_BS + C_STEP >= C_RFACE) && ovl_r) begin
              xs    = C_RSTOP;
              dx_n  = DX_LEFT;
              hit_n = 1'b1;
            end else if (xw + C_BS + C_STEP > C_W) begin
              state_n = SCORED;
            end else begin
              xs = xw + C_STEP;
            end
          end else begin
            if ((xw >= C_LFACE) && (xw <= C_LFACE + C_STEP) && ovl_l) begin
              xs    = C_LFACE;
              dx_n  = DX_RIGHT;
              hit_n = 1'b1;
            end else if (xw < C_STEP) begin
              state_n = SCORED;
            end else begin
              xs = xw - C_STEP;
            end
          end

          // A miss freezes the ball where it was; SCORED recentres it next.
          if (state_n == SCORED) begin
            dy_n = dy;
          end else begin
            x_n = xs[POS_W-1:0];
            y_n = ys[POS_W-1:0];
          end
        end
      end

      SCORED: begin
        x_n     = CX;
        y_n     = CY;
        state_n = IDLE;
        if (dx == DX_RIGHT) begin
          sl_n = 1'b1;
          dx_n = DX_LEFT;
        end else begin
          sr_n = 1'b1;
          dx_n = DX_RIGHT;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign bus.ball_x            = ball_x;
  assign bus.ball_y            = ball_y;
  assign bus.ball_active       = (state == PLAY);
  assign bus.hit_pulse         = hit_q;
  assign bus.score_left_pulse  = sl_q;
  assign bus.score_right_pulse = sr_q;

endmodule

// File: tb/tb_pong_ball.sv
// Directed bench for pong_ball with a short serve delay; table-driven motion
// checks plus hand-written reset, serve and scoring sequences.
module tb_pong_ball;

  logic clk;
  logic rst;

  pong_ball_if bus ();

  pong_ball #(.SERVE_TICKS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         tk;
    logic [9:0] x;
    logic [9:0] y;
    logic       hit;
  } vec_t;

  vec_t tbl[16];
  int   checks = 0;
  int   errors = 0;
  int   tk_now = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick_once();
    @(negedge clk) bus.gClk = 1'b1;
    @(negedge clk) bus.gClk = 1'b0;
    tk_now++;
  endtask

  task automatic check_centre(input string nm);
    chk({nm, "_x"}, 32'(bus.ball_x), 32'd316);
    chk({nm, "_y"}, 32'(bus.ball_y), 32'd236);
    chk({nm, "_active"}, 32'(bus.ball_active), 32'd0);
    chk({nm, "_pulses"},
        32'({bus.hit_pulse, bus.score_left_pulse, bus.score_right_pulse}), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.gClk = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_centre("reset");
    bus.gClk = 1'b0;
  endtask

  // Serve, then two ticks to launch; an extra serve mid-wait must be ignored.
  task automatic serve_launch();
    @(negedge clk) bus.serve = 1'b1;
    @(negedge clk) bus.serve = 1'b0;
    tick_once();
    chk("wait1_active", 32'(bus.ball_active), 32'd0);
    @(negedge clk) bus.serve = 1'b1;
    @(negedge clk) bus.serve = 1'b0;
    tick_once();
    chk("launch_active", 32'(bus.ball_active), 32'd1);
    chk("launch_x", 32'(bus.ball_x), 32'd316);
    chk("launch_y", 32'(bus.ball_y), 32'd236);
    tk_now = 0;
  endtask

  task automatic run_vecs(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      while (tk_now < tbl[i].tk) tick_once();
      chk($sformatf("v%0d_t%0d_x", i, tbl[i].tk), 32'(bus.ball_x), 32'(tbl[i].x));
      chk($sformatf("v%0d_t%0d_y", i, tbl[i].tk), 32'(bus.ball_y), 32'(tbl[i].y));
      chk($sformatf("v%0d_t%0d_hit", i, tbl[i].tk), 32'(bus.hit_pulse), 32'(tbl[i].hit));
    end
  endtask

  initial begin
    bool_init();
    // Play 1: right paddle out of reach, ball exits on the right.
    tbl[0]  = '{72,  10'd604, 10'd420, 1'b0};
    tbl[1]  = '{73,  10'd608, 10'd416, 1'b0};
    tbl[2]  = '{79,  10'd632, 10'd392, 1'b0};
    // Play 2: right paddle hit, top wall, left paddle hit.
    tbl[3]  = '{1,   10'd320, 10'd240, 1'b0};
    tbl[4]  = '{58,  10'd548, 10'd468, 1'b0};
    tbl[5]  = '{59,  10'd552, 10'd472, 1'b0};
    tbl[6]  = '{60,  10'd556, 10'd468, 1'b0};
    tbl[7]  = '{72,  10'd604, 10'd420, 1'b0};
    tbl[8]  = '{73,  10'd608, 10'd416, 1'b1};
    tbl[9]  = '{74,  10'd604, 10'd412, 1'b0};
    tbl[10] = '{176, 10'd196, 10'd4,   1'b0};
    tbl[11] = '{177, 10'd192, 10'd0,   1'b0};
    tbl[12] = '{178, 10'd188, 10'd4,   1'b0};
    tbl[13] = '{218, 10'd28,  10'd164, 1'b0};
    tbl[14] = '{219, 10'd24,  10'd168, 1'b1};
    tbl[15] = '{220, 10'd28,  10'd172, 1'b0};

    do_reset();

    bus.right_paddle_y = 10'd0;
    serve_launch();
    run_vecs(0, 2);
    tick_once();
    chk("miss_tick_left", 32'(bus.score_left_pulse), 32'd0);
    begin : wait_score
      int seen = 0;
      for (int c = 0; c < 4 && seen == 0; c++) begin
        @(negedge clk);
        if (bus.score_left_pulse === 1'b1) seen = 1;
      end
      chk("score_left_seen", 32'(seen), 32'd1);
      chk("score_right_quiet", 32'(bus.score_right_pulse), 32'd0);
      chk("score_x", 32'(bus.ball_x), 32'd316);
      chk("score_y", 32'(bus.ball_y), 32'd236);
      chk("score_active", 32'(bus.ball_active), 32'd0);
      @(negedge clk);
      chk("score_left_width", 32'(bus.score_left_pulse), 32'd0);
      tick_once();
      chk("idle_hold_x", 32'(bus.ball_x), 32'd316);
      chk("idle_active", 32'(bus.ball_active), 32'd0);
    end

    do_reset();
    bus.right_paddle_y = 10'd400;
    serve_launch();
    run_vecs(3, 8);
    @(negedge clk);
    chk("hit_width", 32'(bus.hit_pulse), 32'd0);
    run_vecs(9, 15);
    @(negedge clk);
    chk("lhit_width", 32'(bus.hit_pulse), 32'd0);

    // Reset landing on a PLAY tick wins over the motion update.
    @(negedge clk);
    bus.gClk = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check_centre("midreset");
    rst = 1'b0;
    bus.gClk = 1'b0;
    tick_once();
    check_centre("postreset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic bool_init();
    rst = 1'b1;
    bus.gClk = 1'b0;
    bus.serve = 1'b0;
    bus.left_paddle_y = 10'd150;
    bus.right_paddle_y = 10'd400;
  endtask

endmodule
